multicycle_control_fsm: RTL and testbench

//  Multicycle MIPS controller: the driving end of the ALU interface. Decodes op/funct and sequences

---
 rtl/multicycle_control_fsm_if.sv | 36 +++
 rtl/multicycle_control_fsm.sv | 212 +++++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_fsm_if.sv
// Controller <-> datapath/memory bundle for the multicycle MIPS core.
// master = controller side, slave = datapath side.
interface multicycle_control_fsm_if #(
  parameter int unsigned STATE_W = 4
);
  logic [5:0]         op;
  logic [5:0]         funct;
  logic               zero;
  logic               mem_ready;
  logic               mem_req;
  logic               memwrite;
  logic               iord;
  logic               irwrite;
  logic               regwrite;
  logic               regdst;
  logic               memtoreg;
  logic               alusrca;
  logic [1:0]         alusrcb;
  logic [2:0]         alucontrol;
  logic [1:0]         pcsrc;
  logic               pcen;
  logic               illegal_op;
  logic [STATE_W-1:0] dbg_state;

  modport master (
    input  op, funct, zero, mem_ready,
    output mem_req, memwrite, iord, irwrite, regwrite, regdst, memtoreg,
           alusrca, alusrcb, alucontrol, pcsrc, pcen, illegal_op, dbg_state
  );

  modport slave (
    output op, funct, zero, mem_ready,
    input  mem_req, memwrite, iord, irwrite, regwrite, regdst, memtoreg,
           alusrca, alusrcb, alucontrol, pcsrc, pcen, illegal_op, dbg_state
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS controller: sequences fetch/decode/execute/memory/writeback
// one state per cycle and drives the datapath muxes, ALU op and write enables.
// Controls are decoded from the current state; FETCH enables follow mem_ready
// and pcen folds in the ALU zero flag for branches.
module multicycle_control_fsm #(
  parameter int unsigned STATE_W = 4
) (
  input logic                     clk,
  input logic                     reset_n,
  multicycle_control_fsm_if.master bus
);

  typedef enum logic [STATE_W-1:0] {
    S_FETCH  = STATE_W'(0),
    S_DECODE = STATE_W'(1),
    S_MEMADR = STATE_W'(2),
    S_MEMRD  = STATE_W'(3),
    S_MEMWB  = STATE_W'(4),
    S_MEMWR  = STATE_W'(5),
    S_EXEC   = STATE_W'(6),
    S_ALUWB  = STATE_W'(7),
    S_BRANCH = STATE_W'(8),
    S_ADDIEX = STATE_W'(9),
    S_ADDIWB = STATE_W'(10),
    S_JUMP   = STATE_W'(11),
    S_HALT   = STATE_W'(12)
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t     state_q;
  logic       illegal_q;

  logic       funct_ok;
  logic [2:0] funct_alu;

  logic       mem_req;
  logic       memwrite;
  logic       iord;
  logic       irwrite;
  logic       regwrite;
  logic       regdst;
  logic       memtoreg;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [2:0] alucontrol;
  logic [1:0] pcsrc;
  logic       pcwrite;
  logic       branch;
  logic       pcen;

  // R-type funct to ALU operation; unsupported functs fall back to ADD
  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = ALU_ADD;
    case (bus.funct)
      6'b100000: funct_alu = ALU_ADD;
      6'b100010: funct_alu = ALU_SUB;
      6'b100100: funct_alu = ALU_AND;
      6'b100101: funct_alu = ALU_OR;
      6'b101010: funct_alu = ALU_SLT;
      default:   funct_ok  = 1'b0;
    endcase
  end

  // State sequencing and sticky illegal-instruction flag
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH:  if (bus.mem_ready) state_q <= S_DECODE;
        S_DECODE: begin
          case (bus.op)
            OP_LW, OP_SW: state_q <= S_MEMADR;
            OP_RTYPE:     state_q <= S_EXEC;
            OP_BEQ:       state_q <= S_BRANCH;
            OP_ADDI:      state_q <= S_ADDIEX;
            OP_J:         state_q <= S_JUMP;
            default: begin
              state_q   <= S_HALT;
              illegal_q <= 1'b1;
            end
          endcase
        end
        S_MEMADR: state_q <= (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD:  if (bus.mem_ready) state_q <= S_MEMWB;
        S_MEMWB:  state_q <= S_FETCH;
        S_MEMWR:  if (bus.mem_ready) state_q <= S_FETCH;
        S_EXEC: begin
          if (funct_ok) begin
            state_q <= S_ALUWB;
          end else begin
            state_q   <= S_HALT;
            illegal_q <= 1'b1;
          end
        end
        S_ALUWB:  state_q <= S_FETCH;
        S_BRANCH: state_q <= S_FETCH;
        S_ADDIEX: state_q <= S_ADDIWB;
        S_ADDIWB: state_q <= S_FETCH;
        S_JUMP:   state_q <= S_FETCH;
        S_HALT:   state_q <= S_HALT;
        default:  state_q <= S_FETCH;
      endcase
    end
  end

  // Per-state control decode; everything held at zero while reset_n is low
  always_comb begin
    mem_req    = 1'b0;
    memwrite   = 1'b0;
    iord       = 1'b0;
    irwrite    = 1'b0;
    regwrite   = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    alucontrol = 3'b000;
    pcsrc      = 2'b00;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    if (reset_n) begin
      case (state_q)
        S_FETCH: begin
          mem_req    = 1'b1;
          alusrcb    = 2'b01;
          alucontrol = ALU_ADD;
          irwrite    = bus.mem_ready;
          pcwrite    = bus.mem_ready;
        end
        S_DECODE: begin
          alusrcb    = 2'b11;
          alucontrol = ALU_ADD;
        end
        S_MEMADR: begin
          alusrca    = 1'b1;
          alusrcb    = 2'b10;
          alucontrol = ALU_ADD;
        end
        S_MEMRD: begin
          mem_req = 1'b1;
          iord    = 1'b1;
        end
        S_MEMWB: begin
          memtoreg = 1'b1;
          regwrite = 1'b1;
        end
        S_MEMWR: begin
          mem_req  = 1'b1;
          iord     = 1'b1;
          memwrite = 1'b1;
        end
        S_EXEC: begin
          alusrca    = 1'b1;
          alucontrol = funct_alu;
        end
        S_ALUWB: begin
          regdst   = 1'b1;
          regwrite = 1'b1;
        end
        S_BRANCH: begin
          alusrca    = 1'b1;
          alucontrol = ALU_SUB;
          pcsrc      = 2'b01;
          branch     = 1'b1;
        end
        S_ADDIEX: begin
          alusrca    = 1'b1;
          alusrcb    = 2'b10;
          alucontrol = ALU_ADD;
        end
        S_ADDIWB: regwrite = 1'b1;
        S_JUMP: begin
          pcsrc   = 2'b10;
          pcwrite = 1'b1;
        end
        default: ;
      endcase
    end
    pcen = pcwrite | (branch & bus.zero);
  end

  assign bus.mem_req    = mem_req;
  assign bus.memwrite   = memwrite;
  assign bus.iord       = iord;
  assign bus.irwrite    = irwrite;
  assign bus.regwrite   = regwrite;
  assign bus.regdst     = regdst;
  assign bus.memtoreg   = memtoreg;
  assign bus.alusrca    = alusrca;
  assign bus.alusrcb    = alusrcb;
  assign bus.alucontrol = alucontrol;
  assign bus.pcsrc      = pcsrc;
  assign bus.pcen       = pcen;
  assign bus.illegal_op = illegal_q;
  assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: instruction-level model expands each
// instruction into its expected per-cycle controls, one process drives and
// compares every cycle, and end-of-run tallies are pinned to hand counts.
module tb_multicycle_control_fsm;
  localparam int unsigned STATE_W = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  multicycle_control_fsm_if #(.STATE_W(STATE_W)) bus ();

  multicycle_control_fsm #(.STATE_W(STATE_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct packed {
    logic       mem_req;
    logic       memwrite;
    logic       iord;
    logic       irwrite;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [2:0] alucontrol;
    logic [1:0] pcsrc;
    logic       pcen;
  } ctrl_t;

  typedef struct {
    bit         chk;
    bit         rst_n;
    logic [5:0] op;
    logic [5:0] funct;
    bit         zero;
    bit         mr;
    ctrl_t      c;
    int         st;
    bit         ill;
  } step_t;

  localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;

  step_t      steps[$];
  int         m_next = 0;
  bit         m_ill = 1'b0;
  logic [5:0] cur_op = '0;
  logic [5:0] cur_funct = '0;

  int tests = 0;
  int fails = 0;
  int rw_cnt = 0, mw_cnt = 0, memrd_cnt = 0, ill_cnt = 0, viol_cnt = 0;

  // Instruction class -> state after DECODE (12 = halt)
  function automatic int decode_next(logic [5:0] op);
    case (op)
      LW, SW: return 2;
      RT:     return 6;
      BEQ:    return 8;
      ADDI:   return 9;
      JMP:    return 11;
      default: return 12;
    endcase
  endfunction

  function automatic bit rtype_alu(logic [5:0] f, output logic [2:0] a);
    a = 3'b010;
    case (f)
      6'b100000: a = 3'b010;
      6'b100010: a = 3'b110;
      6'b100100: a = 3'b000;
      6'b100101: a = 3'b001;
      6'b101010: a = 3'b111;
      default:   return 1'b0;
    endcase
    return 1'b1;
  endfunction

  task automatic st(int s, ctrl_t c, bit mr, bit z, int nxt, bit set_ill);
    step_t r;
    r.chk = 1'b1; r.rst_n = 1'b1; r.op = cur_op; r.funct = cur_funct;
    r.zero = z; r.mr = mr; r.c = c; r.st = s; r.ill = m_ill;
    steps.push_back(r);
    m_next = nxt;
    if (set_ill) m_ill = 1'b1;
  endtask

  task automatic rst(int n, bit chk_first);
    for (int i = 0; i < n; i++) begin
      step_t r;
      r.chk = chk_first || (i > 0); r.rst_n = 1'b0; r.op = cur_op; r.funct = cur_funct;
      r.zero = 1'b1; r.mr = 1'b1; r.c = '0; r.st = m_next; r.ill = m_ill;
      steps.push_back(r);
      m_next = 0;
      m_ill  = 1'b0;
    end
  endtask

  task automatic do_fetch(int waits);
    ctrl_t c;
    c = '0; c.mem_req = 1'b1; c.alusrcb = 2'b01; c.alucontrol = 3'b010;
    repeat (waits) st(0, c, 1'b0, 1'b1, 0, 1'b0);
    c.irwrite = 1'b1; c.pcen = 1'b1;
    st(0, c, 1'b1, 1'b1, 1, 1'b0);
  endtask

  task automatic do_decode();
    ctrl_t c;
    int    n;
    c = '0; c.alusrcb = 2'b11; c.alucontrol = 3'b010;
    n = decode_next(cur_op);
    st(1, c, 1'b1, 1'b1, n, n == 12);
  endtask

  task automatic do_memadr();
    ctrl_t c;
    c = '0; c.alusrca = 1'b1; c.alusrcb = 2'b10; c.alucontrol = 3'b010;
    st(2, c, 1'b1, 1'b1, (cur_op == SW) ? 5 : 3, 1'b0);
  endtask

  task automatic halt(int n);
    repeat (n) st(12, ctrl_t'('0), 1'b1, 1'b1, 12, 1'b0);
  endtask

  task automatic instr(logic [5:0] op, logic [5:0] funct, bit z, int fwait, int mwait);
    ctrl_t      c;
    logic [2:0] a;
    bit         ok;
    cur_op = op; cur_funct = funct;
    do_fetch(fwait);
    do_decode();
    case (decode_next(op))
      2: begin
        do_memadr();
        if (op == SW) begin
          c = '0; c.mem_req = 1'b1; c.iord = 1'b1; c.memwrite = 1'b1;
          repeat (mwait) st(5, c, 1'b0, 1'b1, 5, 1'b0);
          st(5, c, 1'b1, 1'b1, 0, 1'b0);
        end else begin
          c = '0; c.mem_req = 1'b1; c.iord = 1'b1;
          repeat (mwait) st(3, c, 1'b0, 1'b1, 3, 1'b0);
          st(3, c, 1'b1, 1'b1, 4, 1'b0);
          c = '0; c.memtoreg = 1'b1; c.regwrite = 1'b1;
          st(4, c, 1'b1, 1'b1, 0, 1'b0);
        end
      end
      6: begin
        ok = rtype_alu(funct, a);
        c = '0; c.alusrca = 1'b1; c.alucontrol = a;
        st(6, c, 1'b1, 1'b1, ok ? 7 : 12, !ok);
        if (ok) begin
          c = '0; c.regdst = 1'b1; c.regwrite = 1'b1;
          st(7, c, 1'b1, 1'b1, 0, 1'b0);
        end
      end
      8: begin
        c = '0; c.alusrca = 1'b1; c.alucontrol = 3'b110; c.pcsrc = 2'b01; c.pcen = z;
        st(8, c, 1'b1, z, 0, 1'b0);
      end
      9: begin
        c = '0; c.alusrca = 1'b1; c.alusrcb = 2'b10; c.alucontrol = 3'b010;
        st(9, c, 1'b1, 1'b1, 10, 1'b0);
        c = '0; c.regwrite = 1'b1;
        st(10, c, 1'b1, 1'b1, 0, 1'b0);
      end
      11: begin
        c = '0; c.pcsrc = 2'b10; c.pcen = 1'b1;
        st(11, c, 1'b1, 1'b1, 0, 1'b0);
      end
      default: ;
    endcase
  endtask

  task automatic check_lit(string name, int got, int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  initial begin
    ctrl_t got;
    step_t r;
    bus.op = '0; bus.funct = '0; bus.zero = 1'b0; bus.mem_ready = 1'b0;

    rst(2, 1'b0);
    instr(RT, 6'b100010, 1'b0, 0, 0);   // sub
    instr(LW, 6'b000000, 1'b0, 0, 3);   // lw, memory stalls 3 cycles
    instr(SW, 6'b000000, 1'b0, 0, 2);   // sw, memory stalls 2 cycles
    instr(BEQ, 6'b000000, 1'b1, 0, 0);  // beq taken
    instr(BEQ, 6'b000000, 1'b0, 0, 0);  // beq not taken
    instr(RT, 6'b101010, 1'b0, 0, 0);   // slt
    instr(RT, 6'b100100, 1'b0, 0, 0);   // and
    instr(RT, 6'b100101, 1'b0, 0, 0);   // or
    instr(ADDI, 6'b000000, 1'b0, 0, 0);
    instr(JMP, 6'b000000, 1'b0, 2, 0);  // fetch stalls 2 cycles
    // sw abandoned by reset while the write is stalled
    cur_op = SW; cur_funct = '0;
    do_fetch(0);
    do_decode();
    do_memadr();
    begin
      ctrl_t c;
      c = '0; c.mem_req = 1'b1; c.iord = 1'b1; c.memwrite = 1'b1;
      st(5, c, 1'b0, 1'b1, 5, 1'b0);
    end
    rst(2, 1'b1);
    instr(RT, 6'b100000, 1'b0, 0, 0);   // add
    instr(RT, 6'b000111, 1'b0, 0, 0);   // unsupported funct
    halt(3);
    rst(1, 1'b1);
    instr(6'b111111, 6'b000000, 1'b0, 0, 0);  // unsupported op
    halt(20);
    rst(1, 1'b1);
    instr(RT, 6'b100000, 1'b0, 0, 0);

    for (int i = 0; i < steps.size(); i++) begin
      r = steps[i];
      @(negedge clk);
      reset_n = r.rst_n;
      bus.op = r.op; bus.funct = r.funct; bus.zero = r.zero; bus.mem_ready = r.mr;
      #1;
      if (r.chk) begin
        got.mem_req = bus.mem_req;   got.memwrite = bus.memwrite; got.iord = bus.iord;
        got.irwrite = bus.irwrite;   got.regwrite = bus.regwrite; got.regdst = bus.regdst;
        got.memtoreg = bus.memtoreg; got.alusrca = bus.alusrca;   got.alusrcb = bus.alusrcb;
        got.alucontrol = bus.alucontrol; got.pcsrc = bus.pcsrc;   got.pcen = bus.pcen;
        tests++;
        if (got !== r.c) begin
          fails++;
          $display("FAIL ctrl step %0d: got %b expected %b", i, got, r.c);
        end
        tests++;
        if (bus.dbg_state !== STATE_W'(r.st)) begin
          fails++;
          $display("FAIL state step %0d: got %0d expected %0d", i, bus.dbg_state, r.st);
        end
        tests++;
        if (bus.illegal_op !== r.ill) begin
          fails++;
          $display("FAIL illegal_op step %0d: got %b expected %b", i, bus.illegal_op, r.ill);
        end
        if (bus.regwrite === 1'b1) rw_cnt++;
        if (bus.memwrite === 1'b1) mw_cnt++;
        if (bus.dbg_state === STATE_W'(3)) memrd_cnt++;
        if (bus.illegal_op === 1'b1) ill_cnt++;
        if ((bus.memwrite === 1'b1) && (bus.regwrite === 1'b1 || bus.irwrite === 1'b1)) viol_cnt++;
      end
    end

    @(negedge clk);
    check_lit("regwrite cycles", rw_cnt, 8);
    check_lit("memwrite cycles", mw_cnt, 4);
    check_lit("MEMRD cycles", memrd_cnt, 4);
    check_lit("illegal_op cycles", ill_cnt, 25);
    check_lit("write exclusivity", viol_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
